// File: rtl/regfile_bypass_sb_pkg.sv
// Shared constants and types for the pipelined register file and its scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    // Architectural zero register: reads as 0, never written, never busy.
    localparam int ZERO_REG  = 0;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] word_t;

endpackage

// File: rtl/regfile_bypass_sb_if.sv
// Decode/writeback-facing bus of the register file: read ports, writeback, issue, flush.
interface regfile_bypass_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NREAD = 2
) ();

    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS) + 1;

    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  we;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  issue_valid;
    logic [AW-1:0]         issue_addr;
    logic                  flush;
    logic [CW-1:0]         busy_count;

    // Pipeline side: decode/issue/writeback drive requests, observe data and hazards.
    modport master (
        output rd_addr, we, wr_addr, wr_data, issue_valid, issue_addr, flush,
        input  rd_data, rd_busy, busy_count
    );

    // Register file side.
    modport slave (
        input  rd_addr, we, wr_addr, wr_data, issue_valid, issue_addr, flush,
        output rd_data, rd_busy, busy_count
    );

endinterface

// File: rtl/regfile_bypass_sb_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, bulk-cleared on flush.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NREAD = 2
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              issue_valid,
    input  logic [$clog2(NREGS)-1:0]          issue_addr,
    input  logic                              we,
    input  logic [$clog2(NREGS)-1:0]          wr_addr,
    input  logic                              flush,
    input  logic [NREAD*$clog2(NREGS)-1:0]    rd_addr,
    output logic [NREAD-1:0]                  rd_busy,
    output logic [$clog2(NREGS):0]            busy_count
);

    localparam int AW = $clog2(NREGS);
    localparam int CW = AW + 1;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [CW-1:0]    count_d;

    // Next-state busy vector: flush beats issue, issue beats a same-cycle writeback.
    always_comb begin
        // NOTE: assigning a default first means every path writes busy_d, so no latch is inferred.
        busy_d = busy_q;
        for (int r = 1; r < NREGS; r++) begin
            if (flush)
                busy_d[r] = 1'b0;
            else if (issue_valid && issue_addr == AW'(r))
                busy_d[r] = 1'b1;
            else if (we && wr_addr == AW'(r))
                busy_d[r] = 1'b0;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    // Popcount of the next-state vector so busy_count tracks busy on the same edge.
    always_comb begin
        count_d = '0;
        for (int r = 0; r < NREGS; r++)
            count_d = count_d + CW'(busy_d[r]);
    end

    // Busy vector and its count.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            busy_q     <= '0;
            busy_count <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_count <= count_d;
        end
    end

    // Hazard per read port; a same-cycle writeback to the source clears it combinationally.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            rd_busy[i] = busy_q[rd_addr[i*AW +: AW]]
                      && !(we && wr_addr == rd_addr[i*AW +: AW])
                      && (rd_addr[i*AW +: AW] != AW'(ZERO_REG));
        end
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Pipelined-core register file: N combinational read ports with writeback bypass,
// one synchronous write port, and a busy scoreboard for the hazard unit.
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NREAD = 2
) (
    input  logic                clk,
    input  logic                rstn,
    regfile_bypass_sb_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];

    // Register storage; entry 0 is never written so it stays 0.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: the array is reset because an all-zero register file is the architectural reset state.
        if (!rstn) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else if (bus.we && bus.wr_addr != AW'(ZERO_REG)) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Read ports: zero register, then writeback bypass, then storage; forced 0 under reset.
    always_comb begin
        logic [AW-1:0] ra;
        ra          = '0;
        bus.rd_data = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra = bus.rd_addr[i*AW +: AW];
            if (!rstn || ra == AW'(ZERO_REG))
                bus.rd_data[i*XLEN +: XLEN] = '0;
            else if (bus.we && bus.wr_addr == ra)
                bus.rd_data[i*XLEN +: XLEN] = bus.wr_data;
            else
                bus.rd_data[i*XLEN +: XLEN] = regs[ra];
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) u_scoreboard (
        .clk         (clk),
        .rstn        (rstn),
        .issue_valid (bus.issue_valid),
        .issue_addr  (bus.issue_addr),
        .we          (bus.we),
        .wr_addr     (bus.wr_addr),
        .flush       (bus.flush),
        .rd_addr     (bus.rd_addr),
        .rd_busy     (bus.rd_busy),
        .busy_count  (bus.busy_count)
    );

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Self-checking bench for regfile_bypass_sb: default configuration plus a
// 16-register, 3-port, 64-bit instance. Expected values go into a queue when
// stimulus is driven and are popped when the DUT output is sampled.
module tb_regfile_bypass_sb;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    regfile_bypass_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus_a ();
    regfile_bypass_sb_if #(.XLEN(64), .NREGS(16), .NREAD(3)) bus_b ();

    regfile_bypass_sb #(.XLEN(32), .NREGS(32), .NREAD(2)) dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_a)
    );

    regfile_bypass_sb #(.XLEN(64), .NREGS(16), .NREAD(3)) dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_b)
    );

    logic [63:0] sb_q [$];
    logic [63:0] e;
    int n_checks = 0;
    int n_errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_a.we = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
        bus_a.issue_valid = 1'b0; bus_a.issue_addr = '0; bus_a.flush = 1'b0;
        bus_b.we = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
        bus_b.issue_valid = 1'b0; bus_b.issue_addr = '0; bus_b.flush = 1'b0;
    endtask

    task automatic test_reset();
        for (int r = 1; r < 32; r++) begin
            bus_a.we = 1'b1; bus_a.wr_addr = 5'(r); bus_a.wr_data = 32'(r * 32'h11);
            tick();
        end
        idle();
        bus_a.issue_valid = 1'b1; bus_a.issue_addr = 5'd2;
        tick();
        idle();
        bus_a.rd_addr = {5'd2, 5'd31};
        sb_q.push_back(64'h20F); sb_q.push_back(64'd1); sb_q.push_back(64'b10);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_data[31:0]) !== e) begin n_errors++; $display("FAIL pre_reset_x31: got %h expected %h", bus_a.rd_data[31:0], e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.busy_count) !== e) begin n_errors++; $display("FAIL pre_reset_count: got %0d expected %0d", bus_a.busy_count, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_busy) !== e) begin n_errors++; $display("FAIL pre_reset_busy: got %b expected %b", bus_a.rd_busy, e); end
        // Assert reset mid-cycle with a writeback pending on a read address.
        #2 rstn = 1'b0;
        bus_a.we = 1'b1; bus_a.wr_addr = 5'd31; bus_a.wr_data = 32'hFFFF_FFFF;
        sb_q.push_back(64'd0); sb_q.push_back(64'd0); sb_q.push_back(64'd0); sb_q.push_back(64'd0);
        #1;
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_data) !== e) begin n_errors++; $display("FAIL in_reset_rd_data: got %h expected %h", bus_a.rd_data, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_busy) !== e) begin n_errors++; $display("FAIL in_reset_rd_busy: got %b expected %b", bus_a.rd_busy, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.busy_count) !== e) begin n_errors++; $display("FAIL in_reset_count: got %0d expected %0d", bus_a.busy_count, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_b.busy_count) !== e) begin n_errors++; $display("FAIL in_reset_count_b: got %0d expected %0d", bus_b.busy_count, e); end
        tick();
        idle();
        rstn = 1'b1;
        for (int r = 0; r < 32; r++) begin
            bus_a.rd_addr = {5'(31 - r), 5'(r)};
            sb_q.push_back(64'd0);
            @(negedge clk);
            e = sb_q.pop_front(); n_checks++;
            if (64'(bus_a.rd_data) !== e) begin n_errors++; $display("FAIL post_reset_read r=%0d: got %h expected %h", r, bus_a.rd_data, e); end
        end
        sb_q.push_back(64'd0);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.busy_count) !== e) begin n_errors++; $display("FAIL post_reset_count: got %0d expected %0d", bus_a.busy_count, e); end
    endtask

    task automatic test_write_read();
        tick();
        bus_a.we = 1'b1; bus_a.wr_addr = 5'd5; bus_a.wr_data = 32'hDEAD_BEEF;
        bus_a.rd_addr = {5'd6, 5'd5};
        sb_q.push_back(64'hDEAD_BEEF); sb_q.push_back(64'd0);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_data[31:0]) !== e) begin n_errors++; $display("FAIL bypass_p0: got %h expected %h", bus_a.rd_data[31:0], e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_data[63:32]) !== e) begin n_errors++; $display("FAIL other_p1: got %h expected %h", bus_a.rd_data[63:32], e); end
        tick();
        bus_a.wr_addr = 5'd6; bus_a.wr_data = 32'hCAFE_0006;
        sb_q.push_back(64'hDEAD_BEEF); sb_q.push_back(64'hCAFE_0006);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_data[31:0]) !== e) begin n_errors++; $display("FAIL stored_p0: got %h expected %h", bus_a.rd_data[31:0], e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_data[63:32]) !== e) begin n_errors++; $display("FAIL bypass_p1: got %h expected %h", bus_a.rd_data[63:32], e); end
        tick();
        idle();
        bus_a.rd_addr = {5'd5, 5'd6};
        sb_q.push_back({32'hDEAD_BEEF, 32'hCAFE_0006});
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_data) !== e) begin n_errors++; $display("FAIL stored_both: got %h expected %h", bus_a.rd_data, e); end
    endtask

    task automatic test_reg0();
        tick();
        bus_a.we = 1'b1; bus_a.wr_addr = 5'd0; bus_a.wr_data = 32'hFFFF_FFFF;
        bus_a.issue_valid = 1'b1; bus_a.issue_addr = 5'd0;
        bus_a.rd_addr = {5'd0, 5'd0};
        sb_q.push_back(64'd0); sb_q.push_back(64'd0);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_data) !== e) begin n_errors++; $display("FAIL x0_no_bypass: got %h expected %h", bus_a.rd_data, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_busy) !== e) begin n_errors++; $display("FAIL x0_busy_same: got %b expected %b", bus_a.rd_busy, e); end
        tick();
        idle();
        sb_q.push_back(64'd0); sb_q.push_back(64'd0); sb_q.push_back(64'd0);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_data) !== e) begin n_errors++; $display("FAIL x0_after_write: got %h expected %h", bus_a.rd_data, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_busy) !== e) begin n_errors++; $display("FAIL x0_busy_after: got %b expected %b", bus_a.rd_busy, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.busy_count) !== e) begin n_errors++; $display("FAIL x0_count: got %0d expected %0d", bus_a.busy_count, e); end
    endtask

    task automatic test_scoreboard();
        tick();
        bus_a.issue_valid = 1'b1; bus_a.issue_addr = 5'd7;
        tick();
        idle();
        bus_a.rd_addr = {5'd7, 5'd7};
        sb_q.push_back(64'b11); sb_q.push_back(64'd1);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_busy) !== e) begin n_errors++; $display("FAIL sb_set_busy: got %b expected %b", bus_a.rd_busy, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.busy_count) !== e) begin n_errors++; $display("FAIL sb_set_count: got %0d expected %0d", bus_a.busy_count, e); end
        tick();
        bus_a.we = 1'b1; bus_a.wr_addr = 5'd7; bus_a.wr_data = 32'h1234;
        sb_q.push_back(64'b00); sb_q.push_back({32'h1234, 32'h1234}); sb_q.push_back(64'd1);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_busy) !== e) begin n_errors++; $display("FAIL sb_wb_busy: got %b expected %b", bus_a.rd_busy, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_data) !== e) begin n_errors++; $display("FAIL sb_wb_data: got %h expected %h", bus_a.rd_data, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.busy_count) !== e) begin n_errors++; $display("FAIL sb_wb_count_same: got %0d expected %0d", bus_a.busy_count, e); end
        tick();
        idle();
        sb_q.push_back(64'd0); sb_q.push_back(64'b00);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.busy_count) !== e) begin n_errors++; $display("FAIL sb_clear_count: got %0d expected %0d", bus_a.busy_count, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_busy) !== e) begin n_errors++; $display("FAIL sb_clear_busy: got %b expected %b", bus_a.rd_busy, e); end
    endtask

    task automatic test_simultaneous();
        tick();
        bus_a.issue_valid = 1'b1; bus_a.issue_addr = 5'd3;
        bus_a.we = 1'b1; bus_a.wr_addr = 5'd3; bus_a.wr_data = 32'h33;
        bus_a.rd_addr = {5'd0, 5'd3};
        sb_q.push_back(64'h33);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_data[31:0]) !== e) begin n_errors++; $display("FAIL sim_bypass: got %h expected %h", bus_a.rd_data[31:0], e); end
        tick();
        idle();
        sb_q.push_back(64'd1); sb_q.push_back(64'b01); sb_q.push_back(64'h33);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.busy_count) !== e) begin n_errors++; $display("FAIL sim_issue_wins_count: got %0d expected %0d", bus_a.busy_count, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_busy) !== e) begin n_errors++; $display("FAIL sim_issue_wins_busy: got %b expected %b", bus_a.rd_busy, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_data[31:0]) !== e) begin n_errors++; $display("FAIL sim_x3_written: got %h expected %h", bus_a.rd_data[31:0], e); end
        tick();
        bus_a.issue_valid = 1'b1; bus_a.issue_addr = 5'd9; bus_a.flush = 1'b1;
        bus_a.we = 1'b1; bus_a.wr_addr = 5'd4; bus_a.wr_data = 32'h55;
        bus_a.rd_addr = {5'd3, 5'd4};
        tick();
        idle();
        bus_a.rd_addr = {5'd9, 5'd4};
        sb_q.push_back(64'd0); sb_q.push_back(64'b00); sb_q.push_back(64'h55);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.busy_count) !== e) begin n_errors++; $display("FAIL flush_count: got %0d expected %0d", bus_a.busy_count, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_busy) !== e) begin n_errors++; $display("FAIL flush_busy: got %b expected %b", bus_a.rd_busy, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_data[31:0]) !== e) begin n_errors++; $display("FAIL flush_write_kept: got %h expected %h", bus_a.rd_data[31:0], e); end
    endtask

    task automatic test_back_to_back();
        tick();
        bus_a.issue_valid = 1'b1; bus_a.issue_addr = 5'd10;
        tick();
        tick();
        idle();
        bus_a.rd_addr = {5'd12, 5'd10};
        tick();
        bus_a.we = 1'b1; bus_a.wr_addr = 5'd12; bus_a.wr_data = 32'hC;
        tick();
        idle();
        sb_q.push_back(64'd1); sb_q.push_back(64'hC); sb_q.push_back(64'b01);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.busy_count) !== e) begin n_errors++; $display("FAIL waw_count: got %0d expected %0d", bus_a.busy_count, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_data[63:32]) !== e) begin n_errors++; $display("FAIL nonbusy_write: got %h expected %h", bus_a.rd_data[63:32], e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_busy) !== e) begin n_errors++; $display("FAIL waw_busy: got %b expected %b", bus_a.rd_busy, e); end
        tick();
        bus_a.we = 1'b1; bus_a.wr_addr = 5'd10; bus_a.wr_data = 32'hA;
        tick();
        idle();
        sb_q.push_back(64'd0); sb_q.push_back(64'b00);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.busy_count) !== e) begin n_errors++; $display("FAIL waw_clear_count: got %0d expected %0d", bus_a.busy_count, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_a.rd_busy) !== e) begin n_errors++; $display("FAIL waw_clear_busy: got %b expected %b", bus_a.rd_busy, e); end
    endtask

    task automatic test_param();
        tick();
        bus_b.we = 1'b1; bus_b.wr_addr = 4'd5; bus_b.wr_data = 64'hA5A5_A5A5_5A5A_5A5A;
        bus_b.rd_addr = {4'd5, 4'd1, 4'd5};
        sb_q.push_back(64'hA5A5_A5A5_5A5A_5A5A); sb_q.push_back(64'd0); sb_q.push_back(64'hA5A5_A5A5_5A5A_5A5A);
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            e = sb_q.pop_front(); n_checks++;
            if (bus_b.rd_data[p*64 +: 64] !== e) begin n_errors++; $display("FAIL b_bypass_p%0d: got %h expected %h", p, bus_b.rd_data[p*64 +: 64], e); end
        end
        tick();
        idle();
        bus_b.rd_addr = {4'd1, 4'd5, 4'd1};
        sb_q.push_back(64'hA5A5_A5A5_5A5A_5A5A);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (bus_b.rd_data[64 +: 64] !== e) begin n_errors++; $display("FAIL b_stored_p1: got %h expected %h", bus_b.rd_data[64 +: 64], e); end
        tick();
        for (int r = 1; r < 16; r++) begin
            bus_b.issue_valid = 1'b1; bus_b.issue_addr = 4'(r);
            tick();
        end
        idle();
        bus_b.rd_addr = {4'd15, 4'd0, 4'd3};
        sb_q.push_back(64'd15); sb_q.push_back(64'b101);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_b.busy_count) !== e) begin n_errors++; $display("FAIL b_all_busy_count: got %0d expected %0d", bus_b.busy_count, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_b.rd_busy) !== e) begin n_errors++; $display("FAIL b_busy_ports: got %b expected %b", bus_b.rd_busy, e); end
        tick();
        bus_b.we = 1'b1; bus_b.wr_addr = 4'd15; bus_b.wr_data = 64'h1;
        bus_b.rd_addr = {4'd3, 4'd15, 4'd15};
        sb_q.push_back(64'b100); sb_q.push_back(64'h1);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_b.rd_busy) !== e) begin n_errors++; $display("FAIL b_wb_clears_busy: got %b expected %b", bus_b.rd_busy, e); end
        e = sb_q.pop_front(); n_checks++;
        if (bus_b.rd_data[64 +: 64] !== e) begin n_errors++; $display("FAIL b_wb_bypass_p1: got %h expected %h", bus_b.rd_data[64 +: 64], e); end
        tick();
        idle();
        sb_q.push_back(64'd14);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_b.busy_count) !== e) begin n_errors++; $display("FAIL b_count_after_wb: got %0d expected %0d", bus_b.busy_count, e); end
        tick();
        bus_b.flush = 1'b1;
        tick();
        idle();
        sb_q.push_back(64'd0); sb_q.push_back(64'b000);
        @(negedge clk);
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_b.busy_count) !== e) begin n_errors++; $display("FAIL b_flush_count: got %0d expected %0d", bus_b.busy_count, e); end
        e = sb_q.pop_front(); n_checks++;
        if (64'(bus_b.rd_busy) !== e) begin n_errors++; $display("FAIL b_flush_busy: got %b expected %b", bus_b.rd_busy, e); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        idle();
        bus_a.rd_addr = '0;
        bus_b.rd_addr = '0;
        #12 rstn = 1'b1;
        test_reset();
        test_write_read();
        test_reg0();
        test_scoreboard();
        test_simultaneous();
        test_back_to_back();
        test_param();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
